// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store.
// Define MEM_PORT_ARB_RR_EN for round-robin tie-breaking; otherwise D has fixed priority over IF.
module mem_port_arbiter #(
    parameter int WAIT_STATES = 2
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        IF_req,
    input  logic [31:0] IF_addr,
    output logic        IF_ready,
    output logic [31:0] IF_rdata,
    input  logic        D_req,
    input  logic        D_we,
    input  logic [31:0] D_addr,
    input  logic [31:0] D_wdata,
    input  logic [1:0]  D_length,
    input  logic        D_signed,
    output logic        D_ready,
    output logic [31:0] D_rdata,
    output logic        MEM_en,
    output logic        MEM_we,
    output logic [31:0] MEM_addr,
    output logic [31:0] MEM_wdata,
    output logic [1:0]  MEM_length,
    output logic        MEM_signed,
    input  logic [31:0] MEM_rdata,
    output logic [1:0]  grant
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  len_q;
    logic        we_q, signed_q;
    logic        take, pick_d, last_cyc;

    assign take     = IF_req | D_req;
    assign last_cyc = (state == ACCESS) && (cnt == 4'(WAIT_STATES));

`ifdef MEM_PORT_ARB_RR_EN
    // 0 = IF, 1 = D; a tie goes to whichever side was not served last
    logic last_owner;
    assign pick_d = D_req && !(IF_req && last_owner);
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset)
            last_owner <= 1'b0;
        else if (state == IDLE && take)
            last_owner <= pick_d;
    end
`else
    assign pick_d = D_req;
`endif

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = (state == IDLE)   ? (take ? ACCESS : IDLE) :
                     (state == ACCESS) ? (last_cyc ? DONE : ACCESS) : IDLE;
        MEM_en     = (state == ACCESS);
        MEM_we     = last_cyc && we_q && (len_q != 2'b00);
        MEM_addr   = MEM_en ? addr_q : '0;
        MEM_wdata  = MEM_en ? wdata_q : '0;
        MEM_length = MEM_en ? len_q : '0;
        MEM_signed = MEM_en && signed_q;
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            cnt      <= '0;
            grant    <= '0;
            IF_ready <= 1'b0;
            D_ready  <= 1'b0;
            IF_rdata <= '0;
            D_rdata  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            len_q    <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            IF_ready <= last_cyc && grant[0];
            D_ready  <= last_cyc && grant[1];
            if (state == IDLE && take) begin
                grant    <= pick_d ? 2'b10 : 2'b01;
                cnt      <= '0;
                addr_q   <= pick_d ? D_addr : {IF_addr[31:2], 2'b00};
                wdata_q  <= pick_d ? D_wdata : '0;
                len_q    <= pick_d ? D_length : 2'b11;
                we_q     <= pick_d && D_we;
                signed_q <= pick_d && D_signed;
            end
            if (state == ACCESS)
                cnt <= cnt + 4'd1;
            if (state == DONE)
                grant <= '0;
            if (last_cyc && grant[0])
                IF_rdata <= MEM_rdata;
            if (last_cyc && grant[1] && !we_q)
                D_rdata <= MEM_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transactions on two arbiters (WAIT_STATES 2 and 0),
// predicted from the transaction-level timing rules and compared each cycle.
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_signed = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [1:0]  d_length = '0;

    logic        a_if_ready, a_d_ready, a_mem_en, a_mem_we, a_mem_signed;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic [1:0]  a_mem_length, a_grant;
    logic        b_if_ready, b_d_ready, b_mem_en, b_mem_we, b_mem_signed;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  b_mem_length, b_grant;

    logic        sel = 1'b0;
    logic        o_if_ready, o_d_ready, o_mem_en, o_mem_we, o_mem_signed;
    logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
    logic [1:0]  o_mem_length, o_grant;

    int n_cmp = 0, n_err = 0;
    bit last_d = 1'b0;
    logic [31:0] e_if_rdata = '0, e_d_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_STATES(2)) dut_a (
        .SYS_clk(clk), .SYS_reset(rst),
        .IF_req(if_req), .IF_addr(if_addr), .IF_ready(a_if_ready), .IF_rdata(a_if_rdata),
        .D_req(d_req), .D_we(d_we), .D_addr(d_addr), .D_wdata(d_wdata), .D_length(d_length),
        .D_signed(d_signed), .D_ready(a_d_ready), .D_rdata(a_d_rdata),
        .MEM_en(a_mem_en), .MEM_we(a_mem_we), .MEM_addr(a_mem_addr), .MEM_wdata(a_mem_wdata),
        .MEM_length(a_mem_length), .MEM_signed(a_mem_signed), .MEM_rdata(mem_rdata), .grant(a_grant)
    );

    mem_port_arbiter #(.WAIT_STATES(0)) dut_b (
        .SYS_clk(clk), .SYS_reset(rst),
        .IF_req(if_req), .IF_addr(if_addr), .IF_ready(b_if_ready), .IF_rdata(b_if_rdata),
        .D_req(d_req), .D_we(d_we), .D_addr(d_addr), .D_wdata(d_wdata), .D_length(d_length),
        .D_signed(d_signed), .D_ready(b_d_ready), .D_rdata(b_d_rdata),
        .MEM_en(b_mem_en), .MEM_we(b_mem_we), .MEM_addr(b_mem_addr), .MEM_wdata(b_mem_wdata),
        .MEM_length(b_mem_length), .MEM_signed(b_mem_signed), .MEM_rdata(mem_rdata), .grant(b_grant)
    );

    assign o_if_ready   = sel ? b_if_ready : a_if_ready;
    assign o_d_ready    = sel ? b_d_ready : a_d_ready;
    assign o_mem_en     = sel ? b_mem_en : a_mem_en;
    assign o_mem_we     = sel ? b_mem_we : a_mem_we;
    assign o_mem_signed = sel ? b_mem_signed : a_mem_signed;
    assign o_if_rdata   = sel ? b_if_rdata : a_if_rdata;
    assign o_d_rdata    = sel ? b_d_rdata : a_d_rdata;
    assign o_mem_addr   = sel ? b_mem_addr : a_mem_addr;
    assign o_mem_wdata  = sel ? b_mem_wdata : a_mem_wdata;
    assign o_mem_length = sel ? b_mem_length : a_mem_length;
    assign o_grant      = sel ? b_grant : a_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, 32'(o_grant), 32'd0);
        chk({tag, "_mem_en"}, 32'(o_mem_en), 32'd0);
        chk({tag, "_mem_we"}, 32'(o_mem_we), 32'd0);
        chk({tag, "_if_ready"}, 32'(o_if_ready), 32'd0);
        chk({tag, "_d_ready"}, 32'(o_d_ready), 32'd0);
        chk({tag, "_if_rdata"}, o_if_rdata, e_if_rdata);
        chk({tag, "_d_rdata"}, o_d_rdata, e_d_rdata);
    endtask

    // Leaves the bench just after the negedge of an IDLE cycle, reset values checked
    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_d = 1'b0;
        e_if_rdata = '0;
        e_d_rdata = '0;
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_mem_addr", o_mem_addr, 32'd0);
    endtask

    // Called just after the negedge of an IDLE cycle; the current inputs are sampled at the next edge
    task automatic do_txn();
        int w = sel ? 0 : 2;
        bit dw, acc, estb;
        logic [31:0] ea, ewd, n_if, n_d;
        logic [1:0] el;
        logic es;
`ifdef MEM_PORT_ARB_RR_EN
        dw = d_req && !(if_req && last_d);
`else
        dw = d_req;
`endif
        last_d = dw;
        ea   = dw ? d_addr : (if_addr & ~32'h3);
        ewd  = dw ? d_wdata : 32'd0;
        el   = dw ? d_length : 2'b11;
        es   = dw && d_signed;
        estb = dw && d_we && (d_length != 2'b00);
        n_if = dw ? e_if_rdata : mem_rdata;
        n_d  = (dw && !d_we) ? mem_rdata : e_d_rdata;
        for (int k = 1; k <= w + 2; k++) begin
            @(negedge clk);
            acc = (k <= w + 1);
            if (k == w + 2) begin
                e_if_rdata = n_if;
                e_d_rdata = n_d;
            end
            chk("grant", 32'(o_grant), 32'(dw ? 2'b10 : 2'b01));
            chk("mem_en", 32'(o_mem_en), 32'(acc));
            chk("mem_we", 32'(o_mem_we), 32'(estb && k == w + 1));
            chk("mem_addr", o_mem_addr, acc ? ea : 32'd0);
            chk("mem_wdata", o_mem_wdata, acc ? ewd : 32'd0);
            chk("mem_len_sgn", 32'({o_mem_length, o_mem_signed}), acc ? 32'({el, es}) : 32'd0);
            chk("if_ready", 32'(o_if_ready), 32'(!dw && k == w + 2));
            chk("d_ready", 32'(o_d_ready), 32'(dw && k == w + 2));
            chk("if_rdata", o_if_rdata, e_if_rdata);
            chk("d_rdata", o_d_rdata, e_d_rdata);
        end
        @(negedge clk);
        chk_quiet("post_idle");
    endtask

    initial begin
        do_reset();
        // single fetch, unaligned address
        if_req = 1'b1; if_addr = 32'h0000_0006; mem_rdata = 32'h0050_0293;
        do_txn();
        if_req = 1'b0;
        // word store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_length = 2'b11;
        mem_rdata = 32'h1234_5678;
        do_txn();
        // null store
        d_length = 2'b00;
        do_txn();
        // both requests held: default build serves D every time, RR build alternates
        do_reset();
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_length = 2'b11;
        d_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = $urandom;
            do_txn();
        end
        if_req = 1'b0; d_req = 1'b0;
        // reset during the 2nd ACCESS cycle of a store
        d_req = 1'b1; d_we = 1'b1; d_length = 2'b11; d_addr = 32'h200; d_wdata = $urandom;
        @(negedge clk);
        chk("abort_grant", 32'(o_grant), 32'(2'b10));
        @(negedge clk);
        chk("abort_acc2_en", 32'(o_mem_en), 32'd1);
        chk("abort_acc2_we", 32'(o_mem_we), 32'd0);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; last_d = 1'b0; e_if_rdata = '0; e_d_rdata = '0;
        chk_quiet("abort_after");
        @(negedge clk);
        chk_quiet("abort_idle");
        if_req = 1'b1; if_addr = $urandom; mem_rdata = $urandom;
        do_txn();
        if_req = 1'b0;
        // random traffic, WAIT_STATES = 2
        for (int i = 0; i < 24; i++) begin
            int r = $urandom_range(1, 3);
            if_req = r[0]; d_req = r[1];
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_we = 1'($urandom); d_signed = 1'($urandom); d_length = 2'($urandom);
            mem_rdata = $urandom;
            do_txn();
        end
        // WAIT_STATES = 0 signed byte load
        do_reset();
        sel = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_length = 2'b01; d_signed = 1'b1; d_addr = 32'h33;
        mem_rdata = 32'hFFFF_FF80;
        do_txn();
        for (int i = 0; i < 10; i++) begin
            int r = $urandom_range(1, 3);
            if_req = r[0]; d_req = r[1];
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_we = 1'($urandom); d_signed = 1'($urandom); d_length = 2'($urandom);
            mem_rdata = $urandom;
            do_txn();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
